nd_1to2: RTL and testbench

- Splitter node: the dual of the 2-to-1 merger.
- Accepts messages on one 4-phase req/ack input channel (rcv0).
- Routes each message by one bit of its destination address into one of two per-output FIFOs.
- Drives two 4-phase output channels (snd0, snd1).
- Sits in the node network wherever one link fans out to two subtrees.

---
 rtl/nd_1to2.sv | 229 ++++++++++++++++++++++
 tb/tb_nd_1to2.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_1to2.sv
// nd_1to2: 1-to-2 splitter node. One 4-phase input channel is routed by a
// single destination-address bit into one of two output FIFOs. Each FIFO
// feeds its own 4-phase output channel. All raw req/ack inputs are debounced.

// Level debouncer: the filtered level follows the raw level only after the
// raw level has differed from it for CKS consecutive samples.
module nd_1to2_db #(
    parameter int CKS = 2
) (
    input  logic gch_clk,
    input  logic gch_reset,
    input  logic raw,
    output logic ckd,
    output logic rdy
);
    localparam int CW = $clog2(CKS + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;

    // ready once CKS samples have been observed since reset
    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            rcnt <= '0;
            rdy  <= 1'b0;
        end else if (!rdy) begin
            if (rcnt == CW'(CKS - 1)) rdy <= 1'b1;
            rcnt <= rcnt + CW'(1);
        end
    end

    // a glitch back to the filtered level restarts the stability count
    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            ckd <= 1'b0;
            cnt <= '0;
        end else if (raw == ckd) begin
            cnt <= '0;
        end else if (cnt == CW'(CKS - 1)) begin
            ckd <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// One output lane: circular FIFO plus 4-phase transmit FSM. The head is
// popped straight into the output message registers when a handshake starts.
module nd_1to2_tx #(
    parameter int FSZ = 2,
    parameter int MW  = 20
) (
    input  logic          gch_clk,
    input  logic          gch_reset,
    input  logic          en,
    input  logic          push,
    input  logic [MW-1:0] push_msg,
    input  logic          ckd_ack,
    output logic          full,
    output logic [MW-1:0] snd_msg,
    output logic          snd_req
);
    localparam int IW = (FSZ > 1) ? $clog2(FSZ) : 1;
    localparam int CW = $clog2(FSZ + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL} tx_st_t;

    tx_st_t        st, st_nx;
    logic [MW-1:0] mem [FSZ];
    logic [IW-1:0] hd, tl;
    logic [CW-1:0] cnt;
    logic          pop;

    assign full    = (cnt == CW'(FSZ));
    assign snd_req = (st == WAIT_ACK);

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(FSZ - 1)) ? '0 : i + IW'(1);
    endfunction

    // next-state: start a handshake only once the previous ack has released
    always_comb begin
        st_nx = st;
        pop   = 1'b0;
        unique case (st)
            IDLE:     if (en && cnt != '0 && !ckd_ack) begin
                          pop   = 1'b1;
                          st_nx = WAIT_ACK;
                      end
            WAIT_ACK: if (ckd_ack)  st_nx = WAIT_REL;
            WAIT_REL: if (!ckd_ack) st_nx = IDLE;
            default:  st_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge gch_clk) begin
        if (gch_reset) st <= IDLE;
        else           st <= st_nx;
    end

    // storage: contents are only meaningful where the count says so
    always_ff @(posedge gch_clk) begin
        if (push) mem[tl] <= push_msg;
    end

    // indices and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            if (push) tl <= nxt(tl);
            if (pop)  hd <= nxt(hd);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    // output message holds from one load to the next
    always_ff @(posedge gch_clk) begin
        if (gch_reset) snd_msg <= '0;
        else if (pop)  snd_msg <= mem[hd];
    end
endmodule

module nd_1to2 #(
    parameter int FSZ         = 2,
    parameter int ASZ         = 6,
    parameter int DSZ         = 4,
    parameter int RSZ         = 4,
    parameter int ROUTE_BIT   = 0,
    parameter int RCV_REQ_CKS = 2,
    parameter int SND_ACK_CKS = 2
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack_out,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req_out,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd1_src,
    output logic [ASZ-1:0] snd1_dst,
    output logic [DSZ-1:0] snd1_dat,
    output logic [RSZ-1:0] snd1_red,
    output logic           snd1_req_out,
    input  logic           snd1_ack
);
    localparam int MW = 2 * ASZ + DSZ + RSZ;

    logic                 rg_rdy;
    logic                 ckd_req, rdy_req;
    logic [1:0]           ack_raw, ckd_ack, rdy_ack;
    logic [1:0]           full, push, snd_req;
    logic [1:0][MW-1:0]   snd_msg;
    logic [MW-1:0]        rcv_msg;
    logic                 tgt, accept;

    assign rcv_msg = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign tgt     = rcv0_dst[ROUTE_BIT];
    // head-of-line: a full target stalls the input even if the other side has room
    assign accept  = gch_ready && ckd_req && !rcv0_ack_out && !full[tgt];
    assign push    = {accept && tgt, accept && !tgt};
    assign ack_raw = {snd1_ack, snd0_ack};

    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = snd_msg[0];
    assign {snd1_src, snd1_dst, snd1_dat, snd1_red} = snd_msg[1];
    assign snd0_req_out = snd_req[0];
    assign snd1_req_out = snd_req[1];

    nd_1to2_db #(.CKS(RCV_REQ_CKS)) u_db_req (
        .gch_clk  (gch_clk),
        .gch_reset(gch_reset),
        .raw      (rcv0_req),
        .ckd      (ckd_req),
        .rdy      (rdy_req)
    );

    for (genvar k = 0; k < 2; k++) begin : g_out
        nd_1to2_db #(.CKS(SND_ACK_CKS)) u_db_ack (
            .gch_clk  (gch_clk),
            .gch_reset(gch_reset),
            .raw      (ack_raw[k]),
            .ckd      (ckd_ack[k]),
            .rdy      (rdy_ack[k])
        );

        nd_1to2_tx #(.FSZ(FSZ), .MW(MW)) u_tx (
            .gch_clk  (gch_clk),
            .gch_reset(gch_reset),
            .en       (gch_ready),
            .push     (push[k]),
            .push_msg (rcv_msg),
            .ckd_ack  (ckd_ack[k]),
            .full     (full[k]),
            .snd_msg  (snd_msg[k]),
            .snd_req  (snd_req[k])
        );
    end

    // node ready: initialised and every debouncer has a valid history
    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            rg_rdy    <= 1'b0;
            gch_ready <= 1'b0;
        end else begin
            rg_rdy    <= 1'b1;
            gch_ready <= rg_rdy && rdy_req && (&rdy_ack);
        end
    end

    // receive ack: one accept per req/ack cycle, released when req drops
    always_ff @(posedge gch_clk) begin
        if (gch_reset)                    rcv0_ack_out <= 1'b0;
        else if (accept)                  rcv0_ack_out <= 1'b1;
        else if (!ckd_req && rcv0_ack_out) rcv0_ack_out <= 1'b0;
    end
endmodule

// File: tb/tb_nd_1to2.sv
// tb_nd_1to2: 4-phase sender and two 4-phase receivers around nd_1to2,
// scored against per-output expected-order queues.
module tb_nd_1to2;
    localparam int ASZ = 6, DSZ = 4, RSZ = 4, FSZ = 2, RB = 0, CKS = 2;
    localparam int MW  = 2 * ASZ + DSZ + RSZ;

    logic           gch_clk = 1'b0;
    logic           gch_reset = 1'b1;
    logic           gch_ready;
    logic [ASZ-1:0] rcv0_src = '0, rcv0_dst = '0;
    logic [DSZ-1:0] rcv0_dat = '0;
    logic [RSZ-1:0] rcv0_red = '0;
    logic           rcv0_req = 1'b0;
    logic           rcv0_ack_out;
    logic [ASZ-1:0] snd0_src, snd0_dst, snd1_src, snd1_dst;
    logic [DSZ-1:0] snd0_dat, snd1_dat;
    logic [RSZ-1:0] snd0_red, snd1_red;
    logic           snd0_req_out, snd1_req_out;
    logic           snd0_ack, snd1_ack;

    logic [1:0]     ack_drv = 2'b00;
    logic [1:0]     rx_en = 2'b11;
    int             dly[2] = '{1, 1};
    bit             rnd_dly = 1'b0;
    int             del_cnt[2] = '{0, 0};
    int             n_tests = 0, n_fail = 0;
    logic [MW-1:0]  exp_q0[$], exp_q1[$];

    logic [1:0]     s_req;
    logic [MW-1:0]  s_msg0, s_msg1;

    assign snd0_ack = ack_drv[0];
    assign snd1_ack = ack_drv[1];
    assign s_req    = {snd1_req_out, snd0_req_out};
    assign s_msg0   = {snd0_src, snd0_dst, snd0_dat, snd0_red};
    assign s_msg1   = {snd1_src, snd1_dst, snd1_dat, snd1_red};

    always #5 gch_clk = ~gch_clk;

    nd_1to2 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .ROUTE_BIT(RB),
              .RCV_REQ_CKS(CKS), .SND_ACK_CKS(CKS)) dut (
        .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(gch_ready),
        .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat),
        .rcv0_red(rcv0_red), .rcv0_req(rcv0_req), .rcv0_ack_out(rcv0_ack_out),
        .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat),
        .snd0_red(snd0_red), .snd0_req_out(snd0_req_out), .snd0_ack(snd0_ack),
        .snd1_src(snd1_src), .snd1_dst(snd1_dst), .snd1_dat(snd1_dat),
        .snd1_red(snd1_red), .snd1_req_out(snd1_req_out), .snd1_ack(snd1_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                         input logic [DSZ-1:0] a, input logic [RSZ-1:0] r);
        return {s, d, a, r};
    endfunction

    function automatic logic rt(input logic [MW-1:0] m);
        return m[DSZ + RSZ + RB];
    endfunction

    // receiver k: capture on req, compare with next expected, then 4-phase ack
    task automatic rx_run(input int k);
        logic [MW-1:0] m, e;
        int n;
        forever begin
            @(negedge gch_clk);
            if (rx_en[k] && s_req[k]) begin
                m = (k == 0) ? s_msg0 : s_msg1;
                if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                    chk($sformatf("rx%0d_unexpected", k), 32'd1, 32'd0);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("rx%0d_msg", k), 32'(m), 32'(e));
                end
                del_cnt[k]++;
                n = dly[k] + (rnd_dly ? int'($urandom_range(0, 3)) : 0);
                repeat (n) @(negedge gch_clk);
                ack_drv[k] = 1'b1;
                n = 0;
                while (s_req[k] && n < 300) begin
                    @(negedge gch_clk);
                    n++;
                end
                if (n >= 300) chk($sformatf("rx%0d_req_release", k), 32'(s_req[k]), 32'd0);
                ack_drv[k] = 1'b0;
            end
        end
    endtask

    // sender: expected order is fixed when req is raised (one message in flight)
    task automatic send(input logic [MW-1:0] m, input string tag);
        int n;
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
        if (rt(m)) exp_q1.push_back(m);
        else       exp_q0.push_back(m);
        rcv0_req = 1'b1;
        n = 0;
        while (!rcv0_ack_out && n < 600) begin
            @(negedge gch_clk);
            n++;
        end
        chk({tag, "_ack_rise"}, 32'(rcv0_ack_out), 32'd1);
        rcv0_req = 1'b0;
        n = 0;
        while (rcv0_ack_out && n < 600) begin
            @(negedge gch_clk);
            n++;
        end
        chk({tag, "_ack_fall"}, 32'(rcv0_ack_out), 32'd0);
    endtask

    // wait for every expected message to be delivered and both outputs idle
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || s_req != 2'b00 ||
                ack_drv != 2'b00) && n < 2000) begin
            @(negedge gch_clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        repeat (6) @(negedge gch_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] m1, m5;
        int n, c0, c1;

        fork
            rx_run(0);
            rx_run(1);
        join_none

        // reset state
        repeat (5) begin
            @(negedge gch_clk);
            chk("rst_ready", 32'(gch_ready), 32'd0);
            chk("rst_req", 32'({s_req, rcv0_ack_out}), 32'd0);
            chk("rst_msg", 32'(s_msg0 | s_msg1), 32'd0);
        end
        gch_reset = 1'b0;
        @(negedge gch_clk);
        chk("rel_ready_first", 32'(gch_ready), 32'd0);
        n = 0;
        while (!gch_ready && n < 20) begin
            @(negedge gch_clk);
            n++;
        end
        chk("rel_ready_by", 32'(n <= CKS + 2), 32'd1);
        chk("rel_ready", 32'(gch_ready), 32'd1);

        // single message to output 0
        send(mk(6'h11, 6'h02, 4'hA, 4'h3), "t2");
        drain("t2");
        chk("t2_cnt0", 32'(del_cnt[0]), 32'd1);
        chk("t2_cnt1", 32'(del_cnt[1]), 32'd0);

        // single message to output 1
        send(mk(6'h2C, 6'h03, 4'h5, 4'h9), "t3");
        drain("t3");
        chk("t3_cnt0", 32'(del_cnt[0]), 32'd1);
        chk("t3_cnt1", 32'(del_cnt[1]), 32'd1);

        // back-pressure and head-of-line blocking
        rx_en[0] = 1'b0;
        m1 = mk(6'h01, 6'h04, 4'h1, 4'h1);
        send(m1, "t4a");
        send(mk(6'h02, 6'h06, 4'h2, 4'h2), "t4b");
        send(mk(6'h03, 6'h08, 4'h3, 4'h3), "t4c");
        @(negedge gch_clk);
        chk("t4_out_req", 32'(snd0_req_out), 32'd1);
        chk("t4_out_msg", 32'(s_msg0), 32'(m1));
        fork
            send(mk(6'h04, 6'h0A, 4'h4, 4'h4), "t4d");
            begin
                repeat (20) @(negedge gch_clk);
                chk("t4_hol_ack", 32'(rcv0_ack_out), 32'd0);
                chk("t4_hol_snd1", 32'(snd1_req_out), 32'd0);
                rx_en[0] = 1'b1;
            end
        join
        m5 = mk(6'h05, 6'h0B, 4'h5, 4'h5);
        send(m5, "t4e");
        drain("t4");
        chk("t4_cnt0", 32'(del_cnt[0]), 32'd5);
        chk("t4_cnt1", 32'(del_cnt[1]), 32'd2);

        // alternating outputs, different receiver delays
        dly = '{1, 4};
        for (int i = 0; i < 8; i++)
            send(mk(6'($urandom), {5'($urandom), 1'(i % 2)}, 4'($urandom), 4'($urandom)), "t5");
        drain("t5");
        chk("t5_cnt0", 32'(del_cnt[0]), 32'd9);
        chk("t5_cnt1", 32'(del_cnt[1]), 32'd6);

        // randomized traffic and receiver timing
        rnd_dly = 1'b1;
        c0 = del_cnt[0];
        c1 = del_cnt[1];
        for (int i = 0; i < 30; i++) begin
            m1 = MW'($urandom);
            if (rt(m1)) c1++;
            else        c0++;
            send(m1, "rnd");
        end
        drain("rnd");
        chk("rnd_cnt0", 32'(del_cnt[0]), 32'(c0));
        chk("rnd_cnt1", 32'(del_cnt[1]), 32'(c1));
        rnd_dly = 1'b0;

        // reset mid-operation: req0 pending, one entry queued on output 1
        rx_en = 2'b00;
        send(mk(6'h21, 6'h10, 4'hC, 4'h1), "t6a");
        send(mk(6'h22, 6'h11, 4'hD, 4'h2), "t6b");
        send(mk(6'h23, 6'h13, 4'hE, 4'h3), "t6c");
        @(negedge gch_clk);
        chk("t6_pre_req", 32'(s_req), 32'd3);
        gch_reset = 1'b1;
        @(negedge gch_clk);
        chk("t6_rst_req", 32'({s_req, rcv0_ack_out}), 32'd0);
        chk("t6_rst_ready", 32'(gch_ready), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        c0 = del_cnt[0];
        c1 = del_cnt[1];
        repeat (3) @(negedge gch_clk);
        gch_reset = 1'b0;
        n = 0;
        while (!gch_ready && n < 20) begin
            @(negedge gch_clk);
            n++;
        end
        chk("t6_ready", 32'(gch_ready), 32'd1);
        rx_en = 2'b11;
        repeat (30) @(negedge gch_clk);
        chk("t6_fifo_empty", 32'(del_cnt[0] + del_cnt[1]), 32'(c0 + c1));
        send(mk(6'h3F, 6'h15, 4'h7, 4'h6), "t6d");
        drain("t6");
        chk("t6_cnt1", 32'(del_cnt[1]), 32'(c1 + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
